// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder: unified word-addressed memory behind the riscv core's
// instruction and data ports, plus a host boot loader that fills the array
// and holds the core in reset until the load session completes.
module riscv_mem_responder #(
    parameter int                   BUS_WIDTH = 32,
    parameter int                   DEPTH     = 1024,
    parameter int                   AW        = 10,
    parameter logic [BUS_WIDTH-1:0] NOP_WORD  = 32'h0000_0033
) (
    input  logic                 clk,
    input  logic                 reset_n,
    // instruction port
    input  logic [BUS_WIDTH-1:0] iaddr,
    output logic [BUS_WIDTH-1:0] idata,
    input  logic                 iwr,
    // data port
    input  logic [BUS_WIDTH-1:0] addr,
    input  logic [BUS_WIDTH-1:0] data_out,
    input  logic                 wr,
    input  logic                 re,
    output logic [BUS_WIDTH-1:0] data_in,
    // boot loader
    output logic                 core_reset,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [BUS_WIDTH-1:0] ld_data,
    input  logic                 ld_last,
    input  logic                 ld_start,
    output logic [AW:0]          ld_count,
    output logic [2:0]           err
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state, state_next;
    logic [BUS_WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]         ptr;
    logic                  load_accept;
    logic                  ptr_at_end;

    // Address decode: word index plus alignment / range qualifiers.
    logic [AW-1:0] i_idx, d_idx;
    logic          i_mis, i_oor, d_mis, d_oor, d_ok, d_act;

    assign i_idx      = iaddr[AW+1:2];
    assign d_idx      = addr[AW+1:2];
    assign i_mis      = (iaddr[1:0] != 2'b00);
    assign d_mis      = (addr[1:0] != 2'b00);
    assign i_oor      = ((iaddr >> (AW + 2)) != '0);
    assign d_oor      = ((addr >> (AW + 2)) != '0);
    assign d_ok       = !d_mis && !d_oor;
    assign d_act      = re || wr;
    assign ptr_at_end = (ptr == AW'(DEPTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset_n) state <= LOAD;
        else          state <= state_next;
    end

    // Next-state and loader handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next  = state;
        core_reset  = 1'b1;
        ld_ready    = 1'b1;
        load_accept = 1'b0;
        unique case (state)
            LOAD: begin
                load_accept = ld_valid;
                if (load_accept && (ld_last || ptr_at_end)) state_next = RUN;
            end
            RUN: begin
                core_reset = 1'b0;
                ld_ready   = 1'b0;
                if (ld_start) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    // Load pointer and session word count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr      <= '0;
            ld_count <= '0;
        end else if (load_accept) begin
            ptr      <= ptr_at_end ? '0 : ptr + 1'b1;
            ld_count <= ld_count + 1'b1;
        end else if (state == RUN && ld_start) begin
            ptr      <= '0;
            ld_count <= '0;
        end
    end

    // Sticky error flags, collected only while the core is running.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err <= '0;
        end else if (state == RUN) begin
            err <= err | {iwr,
                          i_oor | (d_act & d_oor),
                          i_mis | (d_act & d_mis)};
        end
    end

    // Single write port shared by the loader and core stores.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset on purpose; contents survive reset_n
        // so a partially loaded image is retained.
        if (reset_n) begin
            if (load_accept)
                mem[ptr] <= ld_data;
            else if (state == RUN && wr && d_ok)
                mem[d_idx] <= data_out;
        end
    end

    // Zero-latency reads for fetch and load; a simultaneous store is seen
    // only from the next cycle.
    always_comb begin
        idata   = NOP_WORD;
        data_in = '0;
        if (state == RUN) begin
            if (!i_mis && !i_oor) idata = mem[i_idx];
            if (re && d_ok)       data_in = mem[d_idx];
        end
    end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Self-checking bench for riscv_mem_responder: directed boot / store / error /
// reload scenarios followed by randomized traffic, all compared against an
// array-and-integer reference model of the responder.
module tb_riscv_mem_responder;

    localparam int          DEPTH = 1024;
    localparam int          AW    = 10;
    localparam logic [31:0] NOP   = 32'h0000_0033;
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] iaddr, idata, addr, data_out, data_in, ld_data;
    logic        iwr, wr, re, ld_valid, ld_last, ld_start;
    logic        core_reset, ld_ready;
    logic [AW:0] ld_count;
    logic [2:0]  err;

    riscv_mem_responder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .iaddr      (iaddr),
        .idata      (idata),
        .iwr        (iwr),
        .addr       (addr),
        .data_out   (data_out),
        .wr         (wr),
        .re         (re),
        .data_in    (data_in),
        .core_reset (core_reset),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_start   (ld_start),
        .ld_count   (ld_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Reference model.
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    bit          m_run;
    int          m_ptr, m_count;
    logic [2:0]  m_err;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit a_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < LIMIT);
    endfunction

    // Compare all outputs against the model, then advance one clock and
    // apply the same inputs to the model.
    task automatic tick();
        #1;
        check("core_reset", {31'b0, core_reset}, {31'b0, !m_run});
        check("ld_ready",   {31'b0, ld_ready},   {31'b0, !m_run});
        check("ld_count",   32'(ld_count),       32'(m_count));
        check("err",        32'(err),            32'(m_err));
        if (!m_run || !a_ok(iaddr))   check("idata", idata, NOP);
        else if (m_known[iaddr >> 2]) check("idata", idata, m_mem[iaddr >> 2]);
        if (!m_run || !re || !a_ok(addr)) check("data_in", data_in, 32'h0);
        else if (m_known[addr >> 2])      check("data_in", data_in, m_mem[addr >> 2]);

        @(posedge clk);
        if (!reset_n) begin
            m_run = 0; m_ptr = 0; m_count = 0; m_err = '0;
        end else if (!m_run) begin
            if (ld_valid) begin
                m_mem[m_ptr]   = ld_data;
                m_known[m_ptr] = 1;
                m_count++;
                if (ld_last || m_ptr == DEPTH - 1) m_run = 1;
                m_ptr = (m_ptr + 1) % DEPTH;
            end
        end else begin
            if (iwr) m_err[2] = 1'b1;
            if (iaddr[1:0] != 2'b00) m_err[0] = 1'b1;
            if (iaddr >= LIMIT)      m_err[1] = 1'b1;
            if (re || wr) begin
                if (addr[1:0] != 2'b00) m_err[0] = 1'b1;
                if (addr >= LIMIT)      m_err[1] = 1'b1;
            end
            if (wr && a_ok(addr)) begin
                m_mem[addr >> 2]   = data_out;
                m_known[addr >> 2] = 1;
            end
            if (ld_start) begin
                m_run = 0; m_ptr = 0; m_count = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        iaddr = '0; iwr = 0; addr = '0; data_out = '0; wr = 0; re = 0;
        ld_valid = 0; ld_data = '0; ld_last = 0; ld_start = 0;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        ld_valid = 1; ld_data = d; ld_last = last;
        tick();
        ld_valid = 0; ld_last = 0;
    endtask

    initial begin
        m_run = 0; m_ptr = 0; m_count = 0; m_err = '0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        idle();
        reset_n = 0;
        @(negedge clk);
        tick();
        #1;
        check("rst_idata",   idata, NOP);
        check("rst_data_in", data_in, 32'h0);
        check("rst_core",    {31'b0, core_reset}, 32'h1);
        tick();
        reset_n = 1;

        // Boot load of three words, last flagged on the third.
        ld_last = 1; tick(); ld_last = 0;          // ld_last without valid ignored
        load_word(32'h0050_0093, 0);
        load_word(32'h0010_8113, 0);
        load_word(32'h0000_0033, 1);
        #1;
        check("boot_count", 32'(ld_count), 32'd3);
        check("boot_core",  {31'b0, core_reset}, 32'h0);
        iaddr = 32'h4;
        #1 check("boot_idata", idata, 32'h0010_8113);
        tick();

        // Store, then load; store + load returns the old value.
        wr = 1; addr = 32'h40; data_out = 32'hDEAD_BEEF; tick();
        wr = 0; re = 1;
        #1 check("st_ld", data_in, 32'hDEAD_BEEF);
        tick();
        wr = 1; data_out = 32'h1234_5678;
        #1 check("st_ld_same", data_in, 32'hDEAD_BEEF);
        tick();
        wr = 0;
        #1 check("st_ld_new", data_in, 32'h1234_5678);
        tick();
        idle();

        // Boundaries.
        iaddr = 32'h1002;
        #1 check("bad_fetch", idata, NOP);
        tick();
        iaddr = '0;
        check("err0", 32'(err[0]), 32'h1);
        wr = 1; addr = LIMIT; data_out = 32'hFFFF_FFFF; tick();
        wr = 0; addr = '0;
        check("err1", 32'(err[1]), 32'h1);
        #1 check("oor_dropped", idata, 32'h0050_0093);
        iwr = 1; tick(); iwr = 0;
        check("err2", 32'(err[2]), 32'h1);

        // Reload keeps error flags.
        ld_start = 1; tick(); ld_start = 0;
        check("reload_core",  {31'b0, core_reset}, 32'h1);
        check("reload_ready", {31'b0, ld_ready},   32'h1);
        check("reload_count", 32'(ld_count), 32'h0);
        check("reload_err",   32'(err), 32'h7);

        // Reset after two of five words; words must survive.
        load_word(32'hA000_0001, 0);
        load_word(32'hA000_0002, 0);
        reset_n = 0; tick(); reset_n = 1;
        check("mid_count", 32'(ld_count), 32'h0);
        check("mid_core",  {31'b0, core_reset}, 32'h1);
        check("mid_err",   32'(err), 32'h0);
        load_word(32'hB000_0000, 1);
        iaddr = 32'h4;
        #1 check("mid_kept", idata, 32'hA000_0002);
        tick();

        // Full load with no ld_last.
        ld_start = 1; tick(); ld_start = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_valid = 1; ld_data = 32'hC000_0000 + 32'(i);
            tick();
        end
        ld_valid = 0;
        check("full_count", 32'(ld_count), 32'(DEPTH));
        check("full_core",  {31'b0, core_reset}, 32'h0);
        iaddr = LIMIT - 4;
        #1 check("full_last", idata, 32'hC000_0000 + 32'(DEPTH - 1));
        tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            idle();
            reset_n = ($urandom_range(0, 299) != 0);
            iaddr = ($urandom_range(0, 9) != 0) ? ($urandom_range(0, DEPTH - 1) << 2) : $urandom();
            addr  = ($urandom_range(0, 9) != 0) ? ($urandom_range(0, DEPTH - 1) << 2) : $urandom();
            data_out = $urandom();
            wr       = ($urandom_range(0, 9) < 3);
            re       = ($urandom_range(0, 9) < 4);
            iwr      = ($urandom_range(0, 99) == 0);
            ld_start = ($urandom_range(0, 99) == 0);
            ld_valid = ($urandom_range(0, 9) < 6);
            ld_last  = ($urandom_range(0, 9) < 2);
            ld_data  = $urandom();
            tick();
        end
        idle();
        reset_n = 1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
